// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, fully oversampled in the i_clk domain.
// Buffered TX byte goes out on MISO; each received byte is offered through a ready/read handshake.
module spi_slave #(
    parameter logic [7:0] DEFAULT_TX  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_SCLK,
    input  logic       i_SS,
    input  logic       i_MOSI,
    output logic       o_MISO,
    input  logic [7:0] i_DIN,
    input  logic       i_LD_DIN,
    output logic       o_DIN_EMPTY,
    output logic [7:0] o_MOSI_DATA,
    output logic       o_DATA_READY,
    input  logic       i_DATA_READ,
    output logic       o_OVERRUN,
    output logic       o_BUSY
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RELOAD} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   ss_prev_q, ss_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             tx_sr_q, tx_sr_d;
    logic [6:0]             rx_sr_q, rx_sr_d;
    logic [7:0]             tx_buf_q, tx_buf_d;
    logic [7:0]             mosi_data_q, mosi_data_d;
    logic                   din_empty_q, din_empty_d;
    logic                   ready_q, ready_d;
    logic                   overrun_q, overrun_d;

    logic sck_s, ss_s, mosi_s;
    logic sck_rise, sck_fall, ss_fall, ss_rise;
    logic load_tx;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_fall  = ~ss_s & ss_prev_q;
    assign ss_rise  = ss_s & ~ss_prev_q;

    assign o_MISO       = tx_sr_q[7];
    assign o_DIN_EMPTY  = din_empty_q;
    assign o_MOSI_DATA  = mosi_data_q;
    assign o_DATA_READY = ready_q;
    assign o_OVERRUN    = overrun_q;
    assign o_BUSY       = (state_q != IDLE);

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], i_SS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
        sck_prev_d  = sck_s;
        ss_prev_d   = ss_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        tx_buf_d    = tx_buf_q;
        mosi_data_d = mosi_data_q;
        din_empty_d = din_empty_q;
        ready_d     = ready_q;
        overrun_d   = overrun_q;
        load_tx     = 1'b0;

        if (i_LD_DIN) begin
            tx_buf_d    = i_DIN;
            din_empty_d = 1'b0;
        end
        if (i_DATA_READ) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // SS release aborts whatever byte is in flight, in any state
        if (ss_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ss_fall) state_d = LOAD;
                end
                LOAD: begin
                    load_tx   = 1'b1;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_sr_d = {rx_sr_q[5:0], mosi_s};
                        if (bit_cnt_q == 3'd7) begin
                            mosi_data_d = {rx_sr_q, mosi_s};
                            ready_d     = 1'b1;
                            if (ready_q && !i_DATA_READ) overrun_d = 1'b1;
                            bit_cnt_d   = 3'd0;
                            state_d     = RELOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (sck_fall && bit_cnt_q != 3'd0) begin
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end
                RELOAD: begin
                    if (sck_fall) begin
                        load_tx = 1'b1;
                        state_d = SHIFT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A same-cycle i_LD_DIN keeps the buffer full with the new byte
        if (load_tx) begin
            if (!din_empty_q) begin
                tx_sr_d = tx_buf_q;
                if (!i_LD_DIN) din_empty_d = 1'b1;
            end else begin
                tx_sr_d = DEFAULT_TX;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            tx_sr_q     <= DEFAULT_TX;
            rx_sr_q     <= '0;
            tx_buf_q    <= '0;
            mosi_data_q <= '0;
            din_empty_q <= 1'b1;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            ss_prev_q   <= ss_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            tx_buf_q    <= tx_buf_d;
            mosi_data_q <= mosi_data_d;
            din_empty_q <= din_empty_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master with directed and randomized frames,
// checked against a byte-level model of the TX buffer and RX handshake.
module tb_spi_slave;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_SCLK, i_SS, i_MOSI;
    logic       o_MISO;
    logic [7:0] i_DIN;
    logic       i_LD_DIN;
    logic       o_DIN_EMPTY;
    logic [7:0] o_MOSI_DATA;
    logic       o_DATA_READY;
    logic       i_DATA_READ;
    logic       o_OVERRUN;
    logic       o_BUSY;

    int total = 0;
    int bad   = 0;

    // byte-level model state
    logic [7:0] buf_v;
    logic [7:0] cur_tx;
    logic [7:0] exp_data;
    bit         buf_full;
    bit         exp_rdy;
    bit         exp_ovr;

    spi_slave dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_SCLK       (i_SCLK),
        .i_SS         (i_SS),
        .i_MOSI       (i_MOSI),
        .o_MISO       (o_MISO),
        .i_DIN        (i_DIN),
        .i_LD_DIN     (i_LD_DIN),
        .o_DIN_EMPTY  (o_DIN_EMPTY),
        .o_MOSI_DATA  (o_MOSI_DATA),
        .o_DATA_READY (o_DATA_READY),
        .i_DATA_READ  (i_DATA_READ),
        .o_OVERRUN    (o_OVERRUN),
        .o_BUSY       (o_BUSY)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic take(output logic [7:0] v);
        if (buf_full) begin
            v        = buf_v;
            buf_full = 1'b0;
        end else begin
            v = 8'hFF;
        end
    endtask

    task automatic load_buf(input logic [7:0] v);
        i_DIN    = v;
        i_LD_DIN = 1'b1;
        clks(1);
        i_LD_DIN = 1'b0;
        buf_v    = v;
        buf_full = 1'b1;
        clks(1);
        chk("din_empty_after_load", o_DIN_EMPTY, 1'b0);
    endtask

    task automatic do_read();
        i_DATA_READ = 1'b1;
        clks(1);
        i_DATA_READ = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
        clks(1);
        chk("ready_after_read", o_DATA_READY, 1'b0);
        chk("overrun_after_read", o_OVERRUN, 1'b0);
    endtask

    task automatic frame_start();
        i_SS = 1'b0;
        clks(6);
        take(cur_tx);
        chk("busy_in_frame", o_BUSY, 1'b1);
    endtask

    task automatic frame_end();
        i_SS = 1'b1;
        clks(5);
        chk("busy_after_frame", o_BUSY, 1'b0);
    endtask

    // Master drives MOSI and samples MISO while SCLK is low, then raises SCLK.
    task automatic run_byte(input logic [7:0] mo, input int nbits, input bit ld_mid,
                            input logic [7:0] ld_val, input bit rd_coinc);
        logic [7:0] mi;
        logic [7:0] exp_tx;
        int lo, hi, sh;
        mi     = 8'h00;
        exp_tx = cur_tx;
        for (int k = 0; k < nbits; k++) begin
            lo = $urandom_range(5, 8);
            hi = $urandom_range(5, 8);
            i_MOSI = mo[7-k];
            if (ld_mid && k == 4) begin
                clks(2);
                i_DIN    = ld_val;
                i_LD_DIN = 1'b1;
                clks(1);
                i_LD_DIN = 1'b0;
                clks(lo - 3);
            end else begin
                clks(lo);
            end
            mi[7-k] = o_MISO;
            i_SCLK = 1'b1;
            if (rd_coinc && k == 7) begin
                // the synchronized rise is registered on the third clock edge
                clks(2);
                i_DATA_READ = 1'b1;
                clks(1);
                i_DATA_READ = 1'b0;
                clks(hi - 3);
            end else begin
                clks(hi);
            end
            i_SCLK = 1'b0;
        end
        clks(6);
        if (ld_mid) begin
            buf_v    = ld_val;
            buf_full = 1'b1;
        end
        if (nbits == 8) begin
            exp_ovr  = rd_coinc ? 1'b0 : (exp_ovr | exp_rdy);
            exp_rdy  = 1'b1;
            exp_data = mo;
            take(cur_tx);
            chk("miso_byte", mi, exp_tx);
            chk("rx_data", o_MOSI_DATA, exp_data);
            chk("rx_ready", o_DATA_READY, exp_rdy);
            chk("rx_overrun", o_OVERRUN, exp_ovr);
        end else begin
            sh = 8 - nbits;
            chk("miso_partial", mi >> sh, exp_tx >> sh);
            chk("ready_partial", o_DATA_READY, exp_rdy);
        end
        chk("din_empty", o_DIN_EMPTY, !buf_full);
    endtask

    initial begin
        int  n, nb;
        bit  ld, abrt;
        i_rst = 1'b1; i_SCLK = 1'b0; i_SS = 1'b1; i_MOSI = 1'b0;
        i_DIN = 8'h00; i_LD_DIN = 1'b0; i_DATA_READ = 1'b0;
        buf_v = 8'h00; cur_tx = 8'hFF; exp_data = 8'h00;
        buf_full = 1'b0; exp_rdy = 1'b0; exp_ovr = 1'b0;
        clks(3);
        chk("rst_miso", o_MISO, 1'b1);
        chk("rst_din_empty", o_DIN_EMPTY, 1'b1);
        chk("rst_data", o_MOSI_DATA, 8'h00);
        chk("rst_ready", o_DATA_READY, 1'b0);
        chk("rst_overrun", o_OVERRUN, 1'b0);
        chk("rst_busy", o_BUSY, 1'b0);
        i_rst = 1'b0;
        clks(4);

        // buffered A5 out while 3C comes in
        load_buf(8'hA5);
        frame_start();
        run_byte(8'h3C, 8, 1'b0, 8'h00, 1'b0);
        chk("t1_data", o_MOSI_DATA, 8'h3C);
        frame_end();
        do_read();

        // empty buffer gives FF, mid-byte load feeds the second byte
        frame_start();
        run_byte(8'h01, 8, 1'b1, 8'h5A, 1'b0);
        do_read();
        run_byte(8'h02, 8, 1'b0, 8'h00, 1'b0);
        frame_end();
        do_read();

        // two bytes without a read
        frame_start();
        run_byte(8'h11, 8, 1'b0, 8'h00, 1'b0);
        run_byte(8'h22, 8, 1'b0, 8'h00, 1'b0);
        chk("t3_overrun", o_OVERRUN, 1'b1);
        chk("t3_data", o_MOSI_DATA, 8'h22);
        frame_end();
        do_read();

        // read coincident with completion while a byte is pending
        frame_start();
        run_byte(8'h33, 8, 1'b0, 8'h00, 1'b0);
        run_byte(8'h44, 8, 1'b0, 8'h00, 1'b1);
        chk("t6_ready", o_DATA_READY, 1'b1);
        chk("t6_overrun", o_OVERRUN, 1'b0);
        frame_end();
        do_read();

        // aborted frame then clean frame
        frame_start();
        run_byte(8'hE7, 5, 1'b0, 8'h00, 1'b0);
        frame_end();
        chk("t4_no_ready", o_DATA_READY, 1'b0);
        frame_start();
        run_byte(8'hC3, 8, 1'b0, 8'h00, 1'b0);
        chk("t4_data", o_MOSI_DATA, 8'hC3);
        frame_end();
        do_read();

        // reset in the middle of a byte
        frame_start();
        run_byte(8'h7E, 8, 1'b0, 8'h00, 1'b0);
        load_buf(8'hB2);
        run_byte(8'h00, 3, 1'b0, 8'h00, 1'b0);
        i_rst = 1'b1;
        #1;
        chk("t5_miso", o_MISO, 1'b1);
        chk("t5_din_empty", o_DIN_EMPTY, 1'b1);
        chk("t5_data", o_MOSI_DATA, 8'h00);
        chk("t5_ready", o_DATA_READY, 1'b0);
        chk("t5_overrun", o_OVERRUN, 1'b0);
        chk("t5_busy", o_BUSY, 1'b0);
        buf_full = 1'b0; exp_rdy = 1'b0; exp_ovr = 1'b0; exp_data = 8'h00;
        i_SS = 1'b1; i_SCLK = 1'b0;
        clks(3);
        i_rst = 1'b0;
        clks(4);
        load_buf(8'h96);
        frame_start();
        run_byte(8'h5C, 8, 1'b0, 8'h00, 1'b0);
        frame_end();
        do_read();

        // randomized frames
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) load_buf(8'($urandom));
            frame_start();
            for (int b = 0; b < n; b++) begin
                abrt = (b == n - 1) && ($urandom_range(0, 5) == 0);
                nb   = abrt ? $urandom_range(1, 7) : 8;
                ld   = (nb >= 5) && ($urandom_range(0, 2) == 0);
                run_byte(8'($urandom), nb, ld, 8'($urandom),
                         (nb == 8) && ($urandom_range(0, 3) == 0));
                if (nb == 8 && $urandom_range(0, 2) == 0) do_read();
            end
            frame_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
